ast_width_reducer: RTL

AST_WIDTH_REDUCER -- requirements
Module: ast_width_reducer

---
 rtl/ast_width_reducer_pkg.sv | 59 +++++
 rtl/ast_width_reducer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ast_width_reducer_pkg.sv
// -----------------------------------------------------------------------------
// usr_types_and_params
//   Shared types, default widths and beat arithmetic for ast_width_reducer.
//   DATA_IN_W   : wide sink data width (multiple of DATA_OUT_W)
//   DATA_OUT_W  : narrow source data width (multiple of 8)
//   CHANNEL_W   : channel field width
//   EMPTY_IN_W  : sink empty width (bytes)
//   EMPTY_OUT_W : source empty width (bytes)
//   R           : narrow beats per full wide word
// -----------------------------------------------------------------------------
package usr_types_and_params;

    localparam int DATA_IN_W   = 64;
    localparam int DATA_OUT_W  = 16;
    localparam int CHANNEL_W   = 10;
    localparam int EMPTY_IN_W  = $clog2(DATA_IN_W / 8);
    localparam int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1;
    localparam int R           = DATA_IN_W / DATA_OUT_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,   // buffer empty
        SEND = 1'b1    // buffer full, beats pending
    } state_t;

    // Valid bytes in a captured word. Empty only matters on eop words; an
    // out-of-range empty is clamped so at least one byte is always sent.
    function automatic int unsigned valid_bytes(input int unsigned in_bytes,
                                                input int unsigned empty_in,
                                                input logic        eop);
        if (!eop)
            return in_bytes;
        if (empty_in >= in_bytes)
            return 1;
        return in_bytes - empty_in;
    endfunction

    // Index of the last narrow beat for a captured word.
    function automatic int unsigned beat_last_idx(input int unsigned in_bytes,
                                                  input int unsigned out_bytes,
                                                  input int unsigned empty_in,
                                                  input logic        eop);
        int unsigned v;
        v = valid_bytes(in_bytes, empty_in, eop);
        return (v + out_bytes - 1) / out_bytes - 1;
    endfunction

    // Empty bytes reported on the last narrow beat (0 for non-eop words).
    function automatic int unsigned beat_empty(input int unsigned in_bytes,
                                               input int unsigned out_bytes,
                                               input int unsigned empty_in,
                                               input logic        eop);
        int unsigned v;
        int unsigned beats;
        v     = valid_bytes(in_bytes, empty_in, eop);
        beats = (v + out_bytes - 1) / out_bytes;
        return beats * out_bytes - v;
    endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// -----------------------------------------------------------------------------
// ast_width_reducer
//   Avalon-ST width reducer: accepts one wide word, emits it MSB-first as
//   DATA_IN_W/DATA_OUT_W narrow beats (fewer on a short eop word). Ready
//   latency 0 on both sides; the next wide word may load on the same edge as
//   the last narrow beat leaves, so a continuous stream has no bubbles.
//
// Ports
//   clk_i, srst_i                 : clock, asynchronous active-high reset
//   ast_data_i/sop/eop/valid_i    : wide sink
//   ast_empty_i, ast_channel_i    : sink empty (bytes) and channel
//   ast_ready_o                   : sink ready
//   ast_data_o/sop/eop/valid_o    : narrow source
//   ast_empty_o, ast_channel_o    : source empty and channel
//   ast_ready_i                   : source ready
// -----------------------------------------------------------------------------
module ast_width_reducer
    import usr_types_and_params::*;
#(
    parameter int DATA_IN_W   = usr_types_and_params::DATA_IN_W,
    parameter int DATA_OUT_W  = usr_types_and_params::DATA_OUT_W,
    parameter int CHANNEL_W   = usr_types_and_params::CHANNEL_W,
    parameter int EMPTY_IN_W  = $clog2(DATA_IN_W / 8),
    parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,

    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,

    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int IN_BYTES  = DATA_IN_W / 8;
    localparam int OUT_BYTES = DATA_OUT_W / 8;
    localparam int NBEATS    = DATA_IN_W / DATA_OUT_W;
    localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    state_t                 state_q, state_d;

    logic [DATA_IN_W-1:0]   buf_data;
    logic                   buf_sop;
    logic                   buf_eop;
    logic [CHANNEL_W-1:0]   buf_channel;
    logic [BEAT_W-1:0]      last_idx;      // index of final beat of this word
    logic [EMPTY_OUT_W-1:0] empty_last;    // empty to report on final beat
    logic [BEAT_W-1:0]      beat_cnt;

    logic                   last_beat;
    logic                   sink_fire;
    logic                   src_fire;

    assign last_beat = (beat_cnt == last_idx);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ast_ready_o = 1'b0;
        ast_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ast_ready_o = 1'b1;
                if (ast_valid_i)
                    state_d = SEND;
            end
            SEND: begin
                ast_valid_o = 1'b1;
                // Reload in the same cycle the last beat leaves.
                ast_ready_o = last_beat && ast_ready_i;
                if (last_beat && ast_ready_i && !ast_valid_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset forces the sink closed regardless of state.
        if (srst_i)
            ast_ready_o = 1'b0;
    end

    assign sink_fire = ast_valid_i && ast_ready_o;
    assign src_fire  = ast_valid_o && ast_ready_i;

    // ------------------------------------------------------------------
    // Word buffer and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            buf_data    <= '0;
            buf_sop     <= 1'b0;
            buf_eop     <= 1'b0;
            buf_channel <= '0;
            last_idx    <= '0;
            empty_last  <= '0;
            beat_cnt    <= '0;
        end else if (sink_fire) begin
            buf_data    <= ast_data_i;
            buf_sop     <= ast_startofpacket_i;
            buf_eop     <= ast_endofpacket_i;
            buf_channel <= ast_channel_i;
            last_idx    <= BEAT_W'(beat_last_idx(IN_BYTES, OUT_BYTES,
                                                 32'(ast_empty_i), ast_endofpacket_i));
            empty_last  <= EMPTY_OUT_W'(beat_empty(IN_BYTES, OUT_BYTES,
                                                   32'(ast_empty_i), ast_endofpacket_i));
            beat_cnt    <= '0;
        end else if (src_fire) begin
            beat_cnt    <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Source outputs: MSB-first slice select; everything else is decoded
    // from the held buffer so it stays stable while backpressured.
    // ------------------------------------------------------------------
    always_comb begin
        ast_data_o = '0;
        for (int k = 0; k < NBEATS; k++) begin
            if (beat_cnt == BEAT_W'(k))
                ast_data_o = buf_data[DATA_IN_W-1-k*DATA_OUT_W -: DATA_OUT_W];
        end
    end

    assign ast_startofpacket_o = ast_valid_o && buf_sop && (beat_cnt == '0);
    assign ast_endofpacket_o   = ast_valid_o && buf_eop && last_beat;
    assign ast_empty_o         = ast_endofpacket_o ? empty_last : '0;
    assign ast_channel_o       = buf_channel;

endmodule
